// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz raster constants for the timing master and sprite renderers.
// Used by vga_timing_gen (frame counter option: VGA_FRAME_CNT_EN).
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    function automatic logic in_span(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Reset-to-1 shift register aligning a sync line with the sprite pixel pipeline.
// DEPTH=0 is a straight wire.
module vga_sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic Pclk,
    input  logic Rst_n,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk;
            assign unused_clk = Pclk ^ Rst_n;
            assign q_o = d_i;
        end else begin : g_shift
            logic [DEPTH-1:0] sr_q;
            logic [DEPTH-1:0] sr_d;

            if (DEPTH == 1) begin : g_one
                assign sr_d = d_i;
            end else begin : g_many
                assign sr_d = {sr_q[DEPTH-2:0], d_i};
            end

            always_ff @(posedge Pclk or negedge Rst_n) begin
                if (!Rst_n) sr_q <= '1;
                else        sr_q <= sr_d;
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing master: pixel/line counters, registered decodes, animate divider.
// Optional 16-bit frame counter port when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int SYNC_DELAY = 2,
    parameter int ANIM_DIV   = 3
) (
    input  logic                              Pclk,
    input  logic                              Rst_n,
    output logic [vga_timing_pkg::COORD_W-1:0] xx,
    output logic [vga_timing_pkg::COORD_W-1:0] yy,
    output logic                              aactive,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              endframe,
`ifdef VGA_FRAME_CNT_EN
    output logic                              animate,
    output logic [15:0]                       frame_cnt
`else
    output logic                              animate
`endif
);

    import vga_timing_pkg::*;

    localparam int HTOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    coord_t           x_q, x_d, y_q, y_d;
    logic             act_q, act_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             ef_q, ef_d, an_q, an_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Decodes look at the next counter value so they line up with xx/yy.
    always_comb begin
        x_d   = x_q + coord_t'(1);
        y_d   = y_q;
        div_d = div_q;
        an_d  = 1'b0;
        if (x_q == coord_t'(HTOT - 1)) begin
            x_d = '0;
            if (y_q == coord_t'(VTOT - 1)) y_d = '0;
            else                           y_d = y_q + coord_t'(1);
        end
        act_d = (x_d < coord_t'(H_ACTIVE)) && (y_d < coord_t'(V_ACTIVE));
        hs_d  = !in_span(x_d, HS_LO, HS_HI);
        vs_d  = !in_span(y_d, VS_LO, VS_HI);
        ef_d  = (x_d == coord_t'(H_ACTIVE - 1)) && (y_d == coord_t'(V_ACTIVE - 1));
        if (ef_d) begin
            if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_d = '0;
                an_d  = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge Pclk or negedge Rst_n) begin
        if (!Rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            act_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            ef_q  <= 1'b0;
            an_q  <= 1'b0;
            div_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            act_q <= act_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ef_q  <= ef_d;
            an_q  <= an_d;
            div_q <= div_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (ef_d) fc_d = fc_q + 16'd1;
    end

    always_ff @(posedge Pclk or negedge Rst_n) begin
        if (!Rst_n) fc_q <= '0;
        else        fc_q <= fc_d;
    end

    assign frame_cnt = fc_q;
`endif

    vga_sync_delay #(.DEPTH(SYNC_DELAY)) u_hs_dly (
        .Pclk  (Pclk),
        .Rst_n (Rst_n),
        .d_i   (hs_q),
        .q_o   (hsync)
    );

    vga_sync_delay #(.DEPTH(SYNC_DELAY)) u_vs_dly (
        .Pclk  (Pclk),
        .Rst_n (Rst_n),
        .d_i   (vs_q),
        .q_o   (vsync)
    );

    assign xx       = x_q;
    assign yy       = y_q;
    assign aactive  = act_q;
    assign endframe = ef_q;
    assign animate  = an_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: closed-form raster model indexed by cycles since reset release.
// Three geometries/delays; random reset points plus one reset inside the sync region.
module tb_vga_timing_gen;

    logic Pclk = 1'b0;
    logic Rst_n = 1'b0;
    longint t = 0;
    int checks = 0;
    int errors = 0;

    logic [9:0] xa, ya, xb, yb, xc, yc;
    logic aa, hsa, vsa, efa, ana;
    logic ab, hsb, vsb, efb, anb;
    logic ac, hsc, vsc, efc, anc;
    logic [15:0] fca, fcb, fcc;

    always #5 Pclk = ~Pclk;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_DELAY(2), .ANIM_DIV(3)
    ) dut_a (
        .Pclk(Pclk), .Rst_n(Rst_n), .xx(xa), .yy(ya), .aactive(aa),
        .hsync(hsa), .vsync(vsa), .endframe(efa),
`ifdef VGA_FRAME_CNT_EN
        .animate(ana), .frame_cnt(fca)
`else
        .animate(ana)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(3), .V_SYNC(3), .V_BP(4),
        .SYNC_DELAY(0), .ANIM_DIV(1)
    ) dut_b (
        .Pclk(Pclk), .Rst_n(Rst_n), .xx(xb), .yy(yb), .aactive(ab),
        .hsync(hsb), .vsync(vsb), .endframe(efb),
`ifdef VGA_FRAME_CNT_EN
        .animate(anb), .frame_cnt(fcb)
`else
        .animate(anb)
`endif
    );

    vga_timing_gen dut_c (
        .Pclk(Pclk), .Rst_n(Rst_n), .xx(xc), .yy(yc), .aactive(ac),
        .hsync(hsc), .vsync(vsc), .endframe(efc),
`ifdef VGA_FRAME_CNT_EN
        .animate(anc), .frame_cnt(fcc)
`else
        .animate(anc)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fca = '0;
    assign fcb = '0;
    assign fcc = '0;
`endif

    always @(posedge Pclk or negedge Rst_n) begin
        if (!Rst_n) t <= 0;
        else        t <= t + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d rst_n=%0b got %0d expected %0d", nm, t, Rst_n, act, exp);
        end
    endtask

    task automatic check_inst(
        input string nm,
        input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp,
        input int dly, input int adiv,
        input logic [9:0] ax, input logic [9:0] ay,
        input logic aact, input logic ahs, input logic avs,
        input logic aef, input logic aan, input logic [15:0] afc
    );
        longint ht, vt, f, p, q, qx, qy, e, n;
        logic [9:0] ex, ey;
        logic ea, ehs, evs, eef, ean;
        logic [15:0] efcnt;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        f  = ht * vt;
        e  = (ha - 1) + (va - 1) * ht;
        if (!Rst_n) begin
            ex = '0; ey = '0; ea = 1'b0; ehs = 1'b1; evs = 1'b1;
            eef = 1'b0; ean = 1'b0; efcnt = '0;
        end else begin
            p   = t % f;
            ex  = 10'(p % ht);
            ey  = 10'(p / ht);
            ea  = (t > 0) && (p % ht < ha) && (p / ht < va);
            eef = (p == e);
            n   = (t >= e) ? (t - e) / f + 1 : 0;
            ean = eef && (n % adiv == 0);
            efcnt = 16'(n);
            if (t < dly) begin
                ehs = 1'b1;
                evs = 1'b1;
            end else begin
                q   = (t - dly) % f;
                qx  = q % ht;
                qy  = q / ht;
                ehs = !(qx >= ha + hfp && qx < ha + hfp + hsw);
                evs = !(qy >= va + vfp && qy < va + vfp + vsw);
            end
        end
        chk({nm, ".xx"}, 32'(ax), 32'(ex));
        chk({nm, ".yy"}, 32'(ay), 32'(ey));
        chk({nm, ".aactive"}, 32'(aact), 32'(ea));
        chk({nm, ".hsync"}, 32'(ahs), 32'(ehs));
        chk({nm, ".vsync"}, 32'(avs), 32'(evs));
        chk({nm, ".endframe"}, 32'(aef), 32'(eef));
        chk({nm, ".animate"}, 32'(aan), 32'(ean));
`ifdef VGA_FRAME_CNT_EN
        chk({nm, ".frame_cnt"}, 32'(afc), 32'(efcnt));
`else
        if (afc != 16'd0 && efcnt == 16'hFFFF) $display("note %s", nm);
`endif
    endtask

    always @(negedge Pclk) begin
        check_inst("a", 16, 4, 6, 6, 12, 2, 2, 4, 2, 3,
                   xa, ya, aa, hsa, vsa, efa, ana, fca);
        check_inst("b", 20, 3, 5, 4, 10, 3, 3, 4, 0, 1,
                   xb, yb, ab, hsb, vsb, efb, anb, fcb);
        check_inst("c", 640, 16, 96, 48, 480, 10, 2, 33, 2, 3,
                   xc, yc, ac, hsc, vsc, efc, anc, fcc);
        if (Rst_n) begin
            if (t == 1) chk("lit_first_xx_a", 32'(xa), 32'd1);
            if (t == 1) chk("lit_first_act_c", 32'(ac), 32'd1);
            if (t == 367) chk("lit_ef_a", 32'(efa), 32'd1);
            if (t == 367) chk("lit_ef_xx_a", 32'(xa), 32'd15);
            if (t == 367) chk("lit_ef_yy_a", 32'(ya), 32'd11);
            if (t == 367) chk("lit_an1_a", 32'(ana), 32'd0);
            if (t == 1007) chk("lit_an2_a", 32'(ana), 32'd0);
            if (t == 1647) chk("lit_an3_a", 32'(ana), 32'd1);
            if (t == 307) chk("lit_an_b", 32'(anb), 32'd1);
            if (t == 22) chk("lit_hs_b_22", 32'(hsb), 32'd1);
            if (t == 23) chk("lit_hs_b_23", 32'(hsb), 32'd0);
            if (t == 28) chk("lit_hs_b_28", 32'(hsb), 32'd1);
            if (t == 449) chk("lit_vs_a_449", 32'(vsa), 32'd1);
            if (t == 450) chk("lit_vs_a_450", 32'(vsa), 32'd0);
            if (t == 514) chk("lit_vs_a_514", 32'(vsa), 32'd1);
            if (t == 657) chk("lit_hs_c_657", 32'(hsc), 32'd1);
            if (t == 658) chk("lit_hs_c_658", 32'(hsc), 32'd0);
            if (t == 753) chk("lit_hs_c_753", 32'(hsc), 32'd0);
            if (t == 754) chk("lit_hs_c_754", 32'(hsc), 32'd1);
            if (t == 800) chk("lit_wrap_c_yy", 32'(yc), 32'd1);
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge Pclk);
        #2;
    endtask

    task automatic pulse_reset(input int n);
        Rst_n = 1'b0;
        run(n);
        Rst_n = 1'b1;
    endtask

    initial begin
        run(3);
        Rst_n = 1'b1;
        run(2000);
        pulse_reset(3);
        run(470);
        pulse_reset(5);
        run(1500);
        for (int i = 0; i < 8; i++) begin
            run($urandom_range(1, 2000));
            pulse_reset($urandom_range(1, 6));
        end
        run(3000);
        @(negedge Pclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
